fifo_rd_stream: RTL
===================

Name: fifo_rd_stream

Overview:
- Downstream consumer stage for the team's synchronous FIFO.
- Converts the FIFO read port into a valid/ready streaming master interface:
  - The FIFO read port uses rd_en, with rd_data valid one cycle later, and empty.
  - The streaming interface uses m_valid, m_ready and m_data.
- A 2-entry output/skid buffer gives full 1-beat/cycle throughput under backpressure, with no data loss or duplication.
- Sits between the sync FIFO and any ready-driven sink: bus master, serializer or arbiter.

Parameters:
- DATA_WIDTH, 8: width of FIFO data and m_data.
- CNT_WIDTH, 16: width of the beat counter (optional feature only).

Ports:
- clk, input, 1: single clock for all logic.
- rst, input, 1: synchronous, active-high reset.
- fifo_empty, input, 1: FIFO empty flag.
- fifo_rd_data, input, DATA_WIDTH: FIFO read data, valid the cycle after an accepted fifo_rd_en.
- fifo_rd_en, output, 1: FIFO read request (combinational from registered state and fifo_empty).
- m_valid, output, 1: output beat valid.
- m_ready, input, 1: sink accepts the beat when m_valid & m_ready.
- m_data, output, DATA_WIDTH: output beat data.
- beat_cnt, output, CNT_WIDTH: accepted-beat count (present only with FIFO_RD_STREAM_CNT_EN).

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Port names are clk and rst.
- Reset, sampled on the clk edge while rst=1:
  - m_valid=0, m_data=0, both buffer slots empty, in-flight flag=0, beat_cnt=0.
  - fifo_rd_en is forced 0 while rst=1.
- State:
  - out slot: drives m_valid/m_data.
  - skid slot: skid_valid, skid_data.
  - inflight flag: registered fifo_rd_en & ~fifo_empty.
- Definitions:
  - occ = m_valid + skid_valid, range 0..2.
  - pop = m_valid & m_ready.
- Read issue: fifo_rd_en = ~rst & ~fifo_empty & ((occ + inflight - pop) < 2). The FIFO is never read when empty; the buffer never overflows.
- Capture: when inflight=1, fifo_rd_data is written this cycle.
  - It goes to the out slot if the out slot is empty, or is being popped with the skid slot empty.
  - Otherwise it goes to the skid slot.
- Pop with skid_valid=1: skid moves to out. Arriving data goes to skid in the same cycle.
- Ordering: strict FIFO order. Out always holds the oldest beat.
- Latency: fifo_rd_en asserted in cycle N → data captured at the end of N+1 → m_valid=1 in cycle N+2.
- Throughput: with m_ready held 1 and the FIFO non-empty, one beat per cycle in steady state (occ=1, inflight=1).
- Backpressure:
  - With m_valid=1 and m_ready=0, m_data is stable until accepted.
  - At most one further FIFO read lands, in skid. fifo_rd_en stays 0 while occ+inflight=2.
- Boundaries:
  - FIFO goes empty mid-stream: buffered beats still drain, m_valid drops after the last one.
  - m_ready toggling every cycle: no beat lost or duplicated.
  - Reset mid-operation: an in-flight beat and buffered beats are discarded. The FIFO is expected to be reset concurrently.

Optional Feature:
- Macro: FIFO_RD_STREAM_CNT_EN.
- Defined:
  - Port beat_cnt and a CNT_WIDTH counter are built.
  - The counter increments on each pop, wraps modulo 2^CNT_WIDTH, and resets to 0.
- Undefined: no beat_cnt port or counter. All other behaviour is identical.

Test Plan:
- Reset check: rst=1 for 3 cycles with fifo_empty=0 → fifo_rd_en=0, m_valid=0, m_data=0 throughout.
- Latency: FIFO preloaded with 0x11,0x22,0x33 and m_ready=1 → fifo_rd_en at cycle 0; m_valid at cycle 2 with 0x11, then 0x22, 0x33 on consecutive cycles; m_valid=0 afterwards.
- Backpressure: 8 entries 0x00..0x07, m_ready=0 for 10 cycles → exactly 2 FIFO reads, m_data holds 0x00. Release m_ready → 0x00..0x07 in order, 8 beats in 8 consecutive cycles.
- Toggling ready: 16 entries 0xA0..0xAF, m_ready alternating 1/0 → all 16 beats in order, no duplicates, fifo_rd_en never asserted while fifo_empty=1.
- Reset mid-stream: rst for 1 cycle while occ=2 and inflight=1 → m_valid=0 next cycle; no stale beat appears after the FIFO refills with 0x55.
- Counter (macro defined): 300 beats accepted with CNT_WIDTH=8 → beat_cnt=44 (300 mod 256); with the macro undefined the design elaborates without the beat_cnt port.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// FIFO read port to valid/ready stream adapter with a 2-entry out/skid buffer.
// Define FIFO_RD_STREAM_CNT_EN to build the beat_cnt accepted-beat counter.
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  beat_cnt
`endif
);

    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_data;
    logic                  inflight;
    logic                  pop;
    logic                  out_take;
    logic [2:0]            level;

    assign pop = m_valid & m_ready;

    // Slots that will be committed after this edge; a read is only issued if
    // its data is guaranteed a free slot when it lands next cycle.
    assign level      = {2'b00, m_valid} + {2'b00, skid_valid} + {2'b00, inflight} - {2'b00, pop};
    assign fifo_rd_en = ~rst & ~fifo_empty & (level < 3'd2);

    // Arriving data bypasses skid only when nothing older is waiting there.
    assign out_take = inflight & (~m_valid | (pop & ~skid_valid));

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight   <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else begin
            inflight <= fifo_rd_en;
            if (pop && skid_valid) begin
                m_data <= skid_data;
                if (inflight) begin
                    skid_data <= fifo_rd_data;
                end else begin
                    skid_valid <= 1'b0;
                end
            end else if (out_take) begin
                m_valid <= 1'b1;
                m_data  <= fifo_rd_data;
            end else if (pop) begin
                m_valid <= 1'b0;
            end else if (inflight) begin
                skid_valid <= 1'b1;
                skid_data  <= fifo_rd_data;
            end
        end
    end

`ifdef FIFO_RD_STREAM_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (pop) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end
`endif

endmodule
